vx_vopd_collector: RTL and testbench
====================================

Name: vx_vopd_collector

Overview:
- Vector operand collector sitting directly upstream of the VGPR file; acts as master on the VGPR request/response port.
- Accepts one dispatched vector instruction at a time and walks its element groups (lid 0..in_last_lid).
- For each group it issues one VGPR read per used source operand and gathers the tagged responses.
- Presents the complete operand set for that group to the execute stage over a valid/ready handshake.

Parameters:
- NUM_SRC, 3, source operands per instruction; SRC_OPD_W = clog2(NUM_SRC).
- SIMD_WIDTH, 4, lanes per response beat.
- XLEN, 32, bits per lane.
- VL_WIDTH, 4, element-group index width.
- WIS_W, 2, issue warp slot width.
- SID_W, 1, SIMD slice index width.
- REG_BITS, 5, register index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  collector idle, accepts instruction
- in_wis  in  WIS_W  warp slot
- in_sid  in  SID_W  SIMD slice
- in_used  in  NUM_SRC  bit k set = operand k is read
- in_regs  in  NUM_SRC*REG_BITS  register id per operand
- in_last_lid  in  VL_WIDTH  index of last element group (inclusive)
- req_valid  out  1  VGPR read request
- req_ready  in  1  VGPR accepts request
- req_opd_id  out  SRC_OPD_W  operand tag
- req_lid  out  VL_WIDTH  element group
- req_wis  out  WIS_W  warp slot
- req_sid  out  SID_W  SIMD slice
- req_reg_id  out  REG_BITS  register
- rsp_valid  in  1  VGPR response; no backpressure
- rsp_opd_id  in  SRC_OPD_W  response tag
- rsp_data  in  SIMD_WIDTH*XLEN  lane data
- out_valid  out  1  operand set ready
- out_ready  in  1  consumer accepts
- out_data  out  NUM_SRC*SIMD_WIDTH*XLEN  operand k at slice k; unused operands are zero
- out_lid  out  VL_WIDTH  element group
- out_wis  out  WIS_W  warp slot
- out_sid  out  SID_W  SIMD slice
- out_last  out  1  out_lid == last lid

Behaviour:
- Reset values: state IDLE; req_valid=0; out_valid=0; in_ready=1; recv mask=0; lid=0; out_data=0.
- Reset asserted mid-operation drops the instruction and clears all pending state. Responses arriving later are discarded.
- States:
  - IDLE: in_ready=1. On in_valid, latch the instruction, set lid=0, clear the recv mask. If in_used==0, go to OUT; otherwise go to REQ.
  - REQ: req_valid=1 for the lowest-index used operand not yet sent, with req_lid=lid. Advance on req_ready. After the last used operand's handshake, go to WAIT. Request fields stay stable while req_valid && !req_ready.
  - WAIT: when recv mask == in_used, go to OUT.
  - OUT: out_valid=1 with registered fields stable until out_ready.
    - On handshake with lid == last lid: go to IDLE.
    - On handshake otherwise: lid+1, clear the recv mask and data buffer, go to REQ (or stay in OUT if in_used==0).
- Responses are accepted in any state except IDLE.
  - rsp_valid with tag k writes rsp_data into slot k and sets recv bit k.
  - Responses may arrive out of order and in the cycle after the request handshake, including while still in REQ.
- A response is ignored if its tag is unused, already received, or not yet requested. It is flagged by a simulation-only assertion.
- Latency: out_valid rises the cycle after the final response is captured. Single operand, req_ready=1, response 1 cycle later:
  - in handshake at cycle 0
  - req at cycle 1
  - rsp at cycle 2
  - out_valid at cycle 4
- At most one element group is outstanding, so the buffer can never overflow.
- The lid counter stops at in_last_lid. in_last_lid = 2^VL_WIDTH-1 must not wrap.

Optional Feature:
- VX_VOPD_COLLECTOR_PERF_EN
- Defined: adds outputs perf_req_stall (32b, cycles with req_valid && !req_ready), perf_out_stall (32b, cycles with out_valid && !out_ready) and perf_groups (32b, out handshakes).
  - All three reset to 0 and saturate at all-ones.
- Undefined: these ports and counters are absent; functional behaviour is identical.

Test Plan:
- in_used=3'b101, regs {7,_,3}, last_lid=1, ready always, rsp 1 cycle later:
  - reqs issued in order (opd0,reg3,lid0), (opd2,reg7,lid0), then the same for lid1.
  - two out beats; the second has out_last=1.
- Responses returned in reverse tag order (opd2 before opd0): out_data slots correctly placed; slot 1 = 0.
- req_ready held low 5 cycles during REQ: request fields stable throughout; no duplicate request; perf_req_stall=5 when the macro is defined.
- out_ready low 3 cycles on lid0: no new requests issued; out fields stable; lid1 requests start the cycle after the handshake.
- in_used=0, last_lid=2: zero VGPR requests; three zero-data beats lid 0,1,2; out_last on lid2.
- Reset asserted in WAIT with one response pending: next cycle IDLE with in_ready=1; a late response does not corrupt a new instruction's data.

Source files
------------

// File: rtl/vx_vopd_collector_if.sv
// Dispatch, VGPR request/response and execute-side signals of the vector operand collector.
// master = collector view, slave = surrounding pipeline view (dispatch, VGPR file, execute).
interface vx_vopd_collector_if #(
   parameter int NUM_SRC    = 3,
   parameter int SIMD_WIDTH = 4,
   parameter int XLEN       = 32,
   parameter int VL_WIDTH   = 4,
   parameter int WIS_W      = 2,
   parameter int SID_W      = 1,
   parameter int REG_BITS   = 5
);
   localparam int SRC_OPD_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int DW        = SIMD_WIDTH * XLEN;

   logic                         in_valid;
   logic                         in_ready;
   logic [WIS_W-1:0]             in_wis;
   logic [SID_W-1:0]             in_sid;
   logic [NUM_SRC-1:0]           in_used;
   logic [NUM_SRC*REG_BITS-1:0]  in_regs;
   logic [VL_WIDTH-1:0]          in_last_lid;

   logic                         req_valid;
   logic                         req_ready;
   logic [SRC_OPD_W-1:0]         req_opd_id;
   logic [VL_WIDTH-1:0]          req_lid;
   logic [WIS_W-1:0]             req_wis;
   logic [SID_W-1:0]             req_sid;
   logic [REG_BITS-1:0]          req_reg_id;

   logic                         rsp_valid;
   logic [SRC_OPD_W-1:0]         rsp_opd_id;
   logic [DW-1:0]                rsp_data;

   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_SRC*DW-1:0]        out_data;
   logic [VL_WIDTH-1:0]          out_lid;
   logic [WIS_W-1:0]             out_wis;
   logic [SID_W-1:0]             out_sid;
   logic                         out_last;

   modport master (
      input  in_valid, in_wis, in_sid, in_used, in_regs, in_last_lid,
      output in_ready,
      output req_valid, req_opd_id, req_lid, req_wis, req_sid, req_reg_id,
      input  req_ready,
      input  rsp_valid, rsp_opd_id, rsp_data,
      output out_valid, out_data, out_lid, out_wis, out_sid, out_last,
      input  out_ready
   );

   modport slave (
      output in_valid, in_wis, in_sid, in_used, in_regs, in_last_lid,
      input  in_ready,
      input  req_valid, req_opd_id, req_lid, req_wis, req_sid, req_reg_id,
      output req_ready,
      output rsp_valid, rsp_opd_id, rsp_data,
      input  out_valid, out_data, out_lid, out_wis, out_sid, out_last,
      output out_ready
   );
endinterface

// File: rtl/vx_vopd_collector.sv
// Vector operand collector: walks element groups, reads used operands from the VGPR file, emits operand sets.
// Optional macro VX_VOPD_COLLECTOR_PERF_EN adds saturating stall/group performance counters.
module vx_vopd_collector #(
   parameter int NUM_SRC    = 3,
   parameter int SIMD_WIDTH = 4,
   parameter int XLEN       = 32,
   parameter int VL_WIDTH   = 4,
   parameter int WIS_W      = 2,
   parameter int SID_W      = 1,
   parameter int REG_BITS   = 5
) (
   input  logic clk,
   input  logic reset,
   vx_vopd_collector_if.master bus
`ifdef VX_VOPD_COLLECTOR_PERF_EN
   ,
   output logic [31:0] perf_req_stall,
   output logic [31:0] perf_out_stall,
   output logic [31:0] perf_groups
`endif
);
   localparam int SRC_OPD_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int DW        = SIMD_WIDTH * XLEN;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t                      state, state_n;
   logic [WIS_W-1:0]            wis;
   logic [SID_W-1:0]            sid;
   logic [NUM_SRC-1:0]          used, sent, recv;
   logic [NUM_SRC*REG_BITS-1:0] regs;
   logic [VL_WIDTH-1:0]         last_lid, lid;
   logic [NUM_SRC*DW-1:0]       data;

   logic [NUM_SRC-1:0]          pend, sel_oh, rsp_hit, rsp_take;
   logic [SRC_OPD_W-1:0]        sel;
   logic                        in_fire, req_fire, out_fire, last_req, last_grp;

   assign in_fire  = (state == IDLE) && bus.in_valid;
   assign req_fire = (state == REQ) && bus.req_ready;
   assign out_fire = (state == OUT) && bus.out_ready;
   assign last_grp = (lid == last_lid);

   // Lowest-index used operand that has not been requested yet for this group.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pend   = used & ~sent;
      sel_oh = pend & (~pend + 1'b1);
      sel    = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--)
         if (pend[k]) sel = SRC_OPD_W'(k);
      last_req = ((pend & ~sel_oh) == '0);
   end

   always_comb begin
      rsp_hit = '0;
      for (int k = 0; k < NUM_SRC; k++)
         rsp_hit[k] = bus.rsp_valid && (state != IDLE) && (bus.rsp_opd_id == SRC_OPD_W'(k));
      rsp_take = rsp_hit & used & sent & ~recv;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (in_fire) state_n = (bus.in_used == '0) ? OUT : REQ;
         REQ:  if (req_fire && last_req) state_n = WAIT;
         WAIT: if (recv == used) state_n = OUT;
         OUT:  if (out_fire) state_n = last_grp ? IDLE : ((used == '0) ? OUT : REQ);
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready   = (state == IDLE);
      bus.req_valid  = (state == REQ);
      bus.req_opd_id = sel;
      bus.req_lid    = lid;
      bus.req_wis    = wis;
      bus.req_sid    = sid;
      bus.req_reg_id = regs[int'(sel)*REG_BITS +: REG_BITS];
      bus.out_valid  = (state == OUT);
      bus.out_data   = data;
      bus.out_lid    = lid;
      bus.out_wis    = wis;
      bus.out_sid    = sid;
      bus.out_last   = last_grp;
   end

   // NOTE: the operand buffer is reset too, since out_data must read zero straight after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wis      <= '0;
         sid      <= '0;
         used     <= '0;
         regs     <= '0;
         last_lid <= '0;
         lid      <= '0;
         sent     <= '0;
         recv     <= '0;
         data     <= '0;
      end else if (in_fire) begin
         wis      <= bus.in_wis;
         sid      <= bus.in_sid;
         used     <= bus.in_used;
         regs     <= bus.in_regs;
         last_lid <= bus.in_last_lid;
         lid      <= '0;
         sent     <= '0;
         recv     <= '0;
         data     <= '0;
      end else if (out_fire && !last_grp) begin
         lid  <= lid + VL_WIDTH'(1);
         sent <= '0;
         recv <= '0;
         data <= '0;
      end else begin
         if (req_fire) sent <= sent | sel_oh;
         recv <= recv | rsp_take;
         for (int k = 0; k < NUM_SRC; k++)
            if (rsp_take[k]) data[k*DW +: DW] <= bus.rsp_data;
      end
   end

`ifdef VX_VOPD_COLLECTOR_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_req_stall <= '0;
         perf_out_stall <= '0;
         perf_groups    <= '0;
      end else begin
         if ((state == REQ) && !bus.req_ready && !(&perf_req_stall)) perf_req_stall <= perf_req_stall + 32'd1;
         if ((state == OUT) && !bus.out_ready && !(&perf_out_stall)) perf_out_stall <= perf_out_stall + 32'd1;
         if (out_fire && !(&perf_groups)) perf_groups <= perf_groups + 32'd1;
      end
   end
`endif

`ifndef SYNTHESIS
   // Unused, duplicate or not-yet-requested tags are dropped by the datapath; make them visible in simulation.
   a_rsp_legal: assert property (@(posedge clk) disable iff (reset)
      (bus.rsp_valid && (state != IDLE)) |-> (rsp_take != '0))
      else $error("vx_vopd_collector: ignored response tag %0d", bus.rsp_opd_id);
`endif
endmodule

// File: tb/tb_vx_vopd_collector.sv
// Scoreboard bench for vx_vopd_collector: a model expands each instruction into expected requests and beats,
// a VGPR responder model answers requests, and monitors compare DUT traffic against the queues.
`timescale 1ns/1ps
module tb_vx_vopd_collector;
   localparam int NUM_SRC = 3, SIMD_WIDTH = 4, XLEN = 32, VL_WIDTH = 4, WIS_W = 2, SID_W = 1, REG_BITS = 5;
   localparam int OW = 2;
   localparam int DW = SIMD_WIDTH * XLEN;

   typedef struct packed {
      logic [OW-1:0]       opd;
      logic [VL_WIDTH-1:0] lid;
      logic [WIS_W-1:0]    wis;
      logic [SID_W-1:0]    sid;
      logic [REG_BITS-1:0] rg;
   } req_t;

   typedef struct packed {
      logic [NUM_SRC*DW-1:0] data;
      logic [VL_WIDTH-1:0]   lid;
      logic [WIS_W-1:0]      wis;
      logic [SID_W-1:0]      sid;
      logic                  last;
   } out_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vx_vopd_collector_if #(.NUM_SRC(NUM_SRC), .SIMD_WIDTH(SIMD_WIDTH), .XLEN(XLEN), .VL_WIDTH(VL_WIDTH),
                          .WIS_W(WIS_W), .SID_W(SID_W), .REG_BITS(REG_BITS)) bus ();

`ifdef VX_VOPD_COLLECTOR_PERF_EN
   logic [31:0] perf_req_stall, perf_out_stall, perf_groups;
   logic [31:0] snap_rs, snap_os, snap_gr;
`endif

   vx_vopd_collector #(.NUM_SRC(NUM_SRC), .SIMD_WIDTH(SIMD_WIDTH), .XLEN(XLEN), .VL_WIDTH(VL_WIDTH),
                       .WIS_W(WIS_W), .SID_W(SID_W), .REG_BITS(REG_BITS)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      ,
      .perf_req_stall(perf_req_stall),
      .perf_out_stall(perf_out_stall),
      .perf_groups   (perf_groups)
`endif
   );

   int   n_checks = 0, n_fail = 0;
   req_t exp_req[$];
   out_t exp_out[$];
   logic [31:0] cur_salt;
   int   req_hs_count = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Lane data the VGPR model returns for a request; depends only on the request and the instruction salt.
   function automatic logic [DW-1:0] opd_data(input logic [31:0] salt, input req_t r);
      logic [DW-1:0] d;
      for (int j = 0; j < SIMD_WIDTH; j++)
         d[j*XLEN +: XLEN] = (salt ^ 32'({r, 8'(j)})) * 32'h9E3779B1 + 32'(j);
      return d;
   endfunction

   // ---------------- ready drivers ----------------
   int req_mode = 0, out_mode = 0;
   bit req_hold = 0, out_hold = 0;
   always @(posedge clk) begin
      #1;
      bus.req_ready = req_hold ? 1'b0 : ((req_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.out_ready = out_hold ? 1'b0 : ((out_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1);
   end

   // ---------------- VGPR responder model ----------------
   // rsp_mode: 0 oldest next cycle, 1 newest-first once batch_n pending, 2 random pick, 3 hold (fire on request)
   req_t pending[$];
   int   rsp_mode = 0, batch_n = 1, fire_req = 0, fire_done = 0, inject_req = 0, inject_done = 0;
   bit   drain = 0;
   logic [OW-1:0] inject_tag = '0;
   req_t seen_r, fire_r;
   int   fire_idx;

   always @(negedge clk) begin
      if (reset) pending.delete();
      else if (bus.req_valid && bus.req_ready) begin
         seen_r.opd = bus.req_opd_id; seen_r.lid = bus.req_lid; seen_r.wis = bus.req_wis;
         seen_r.sid = bus.req_sid;    seen_r.rg  = bus.req_reg_id;
         pending.push_back(seen_r);
      end
   end

   always @(posedge clk) begin
      #1;
      bus.rsp_valid  = 1'b0;
      bus.rsp_opd_id = '0;
      bus.rsp_data   = '0;
      fire_idx       = -1;
      if (inject_done != inject_req) begin
         bus.rsp_valid  = 1'b1;
         bus.rsp_opd_id = inject_tag;
         bus.rsp_data   = {SIMD_WIDTH{32'hDEADBEEF}};
         inject_done++;
      end else if (!reset && pending.size() > 0) begin
         case (rsp_mode)
            0: fire_idx = 0;
            1: begin
               if (pending.size() >= batch_n) drain = 1;
               if (drain) fire_idx = pending.size() - 1;
            end
            2: if ($urandom_range(0, 1) == 1) fire_idx = $urandom_range(0, pending.size() - 1);
            default: if (fire_req != fire_done) begin fire_idx = 0; fire_done++; end
         endcase
         if (fire_idx >= 0) begin
            fire_r = pending[fire_idx];
            pending.delete(fire_idx);
            bus.rsp_valid  = 1'b1;
            bus.rsp_opd_id = fire_r.opd;
            bus.rsp_data   = opd_data(cur_salt, fire_r);
         end
      end
      if (pending.size() == 0) drain = 0;
   end

   // ---------------- monitor / scoreboard ----------------
   req_t cur_r, prev_r;
   out_t cur_o, prev_o;
   bit   prev_rs = 0, prev_os = 0;
   always @(negedge clk) begin
      if (reset) begin
         prev_rs = 0;
         prev_os = 0;
      end else begin
         cur_r.opd = bus.req_opd_id; cur_r.lid = bus.req_lid; cur_r.wis = bus.req_wis;
         cur_r.sid = bus.req_sid;    cur_r.rg  = bus.req_reg_id;
         cur_o.data = bus.out_data; cur_o.lid = bus.out_lid; cur_o.wis = bus.out_wis;
         cur_o.sid  = bus.out_sid;  cur_o.last = bus.out_last;
         if (prev_rs) check("req_stable", {bus.req_valid, cur_r}, {1'b1, prev_r});
         if (prev_os) check("out_stable", {bus.out_valid, cur_o}, {1'b1, prev_o});
         if (bus.req_valid && bus.req_ready) begin
            req_hs_count++;
            if (exp_req.size() == 0) check("req_unexpected", 1, 0);
            else check("req", cur_r, exp_req.pop_front());
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_out.size() == 0) check("out_unexpected", 1, 0);
            else check("out_beat", cur_o, exp_out.pop_front());
         end
         prev_rs = bus.req_valid && !bus.req_ready;
         prev_os = bus.out_valid && !bus.out_ready;
         prev_r  = cur_r;
         prev_o  = cur_o;
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [WIS_W-1:0] w, input logic [SID_W-1:0] s, input logic [NUM_SRC-1:0] u,
                        input logic [NUM_SRC*REG_BITS-1:0] rg, input logic [VL_WIDTH-1:0] last);
      int   guard = 0;
      req_t r;
      out_t o;
      @(posedge clk); #1;
      while (!bus.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
      check("in_ready_before_issue", bus.in_ready, 1);
      for (int l = 0; l <= int'(last); l++) begin
         o.data = '0; o.lid = VL_WIDTH'(l); o.wis = w; o.sid = s; o.last = (l == int'(last));
         for (int k = 0; k < NUM_SRC; k++) if (u[k]) begin
            r.opd = OW'(k); r.lid = VL_WIDTH'(l); r.wis = w; r.sid = s; r.rg = rg[k*REG_BITS +: REG_BITS];
            exp_req.push_back(r);
            o.data[k*DW +: DW] = opd_data(cur_salt, r);
         end
         exp_out.push_back(o);
      end
      // NOTE: bench inputs are driven with blocking assignments just after the active edge.
      bus.in_valid = 1'b1; bus.in_wis = w; bus.in_sid = s; bus.in_used = u;
      bus.in_regs = rg; bus.in_last_lid = last;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      bit done = 0;
      while (!done && n < budget) begin
         @(negedge clk); n++;
         done = (exp_out.size() == 0) && (exp_req.size() == 0) && bus.in_ready;
      end
      check("instr_complete", done, 1);
      if (!done) begin exp_req.delete(); exp_out.delete(); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ns, snap_hs;
      bit seen;
      bus.in_valid = 1'b0; bus.in_wis = '0; bus.in_sid = '0; bus.in_used = '0;
      bus.in_regs = '0; bus.in_last_lid = '0;
      cur_salt = 32'h1234_5678;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_req_valid", bus.req_valid, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      check("rst_perf", {perf_req_stall, perf_out_stall, perf_groups}, 0);
`endif
      @(posedge clk); #1 reset = 1'b0;

      // used=101, regs {7,_,3}, two groups, in-order 1-cycle responses
      issue(2'd2, 1'b1, 3'b101, {5'd7, 5'd0, 5'd3}, 4'd1);
      wait_done(100);

      // single operand latency: out_valid four cycles after the input handshake cycle
      cur_salt = $urandom;
      issue(2'd1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, 4'd0);
      n = 0; seen = 0;
      while (!seen && n < 20) begin @(negedge clk); n++; seen = bus.out_valid; end
      check("latency_cycles", n, 4);
      wait_done(50);

      // reverse-order responses
      rsp_mode = 1; batch_n = 2; cur_salt = $urandom;
      issue(2'd3, 1'b0, 3'b101, {5'd21, 5'd4, 5'd11}, 4'd1);
      wait_done(100);
      rsp_mode = 0;

      // req_ready low for 5 request cycles
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      snap_rs = perf_req_stall; snap_gr = perf_groups;
`endif
      req_hold = 1; cur_salt = $urandom;
      issue(2'd0, 1'b1, 3'b111, {5'd1, 5'd2, 5'd30}, 4'd0);
      ns = 0; n = 0;
      while (ns < 5 && n < 50) begin @(negedge clk); n++; if (bus.req_valid && !bus.req_ready) ns++; end
      req_hold = 0;
      check("req_stall_cycles", ns, 5);
      wait_done(100);
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      check("perf_req_stall", perf_req_stall - snap_rs, 5);
      check("perf_groups", perf_groups - snap_gr, 1);
`endif

      // out_ready low for 3 cycles on lid0; next group requests start right after the handshake
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      snap_os = perf_out_stall;
`endif
      out_hold = 1; cur_salt = $urandom;
      issue(2'd1, 1'b1, 3'b101, {5'd15, 5'd0, 5'd16}, 4'd1);
      ns = 0; n = 0;
      while (ns < 3 && n < 50) begin
         @(negedge clk); n++;
         if (bus.out_valid && !bus.out_ready) begin
            ns++;
            check("no_req_while_out", bus.req_valid, 0);
         end
      end
      out_hold = 0;
      seen = 0; n = 0;
      while (!seen && n < 10) begin @(negedge clk); n++; seen = bus.out_valid && bus.out_ready; end
      check("out_handshake_seen", seen, 1);
      @(negedge clk);
      check("req_after_out", {bus.req_valid, bus.req_lid}, {1'b1, 4'd1});
      wait_done(100);
`ifdef VX_VOPD_COLLECTOR_PERF_EN
      check("perf_out_stall", perf_out_stall - snap_os, 3);
`endif

      // no used operands: three zero beats, no VGPR traffic
      snap_hs = req_hs_count;
      issue(2'd2, 1'b0, 3'b000, {5'd3, 5'd2, 5'd1}, 4'd2);
      wait_done(50);
      check("no_vgpr_reqs", req_hs_count - snap_hs, 0);

      // last lid at the top of the counter range must not wrap
      cur_salt = $urandom;
      issue(2'd3, 1'b1, 3'b010, {5'd0, 5'd19, 5'd0}, 4'd15);
      wait_done(300);

      // reset in WAIT with one response still outstanding
      rsp_mode = 3; cur_salt = $urandom; snap_hs = req_hs_count;
      issue(2'd1, 1'b0, 3'b011, {5'd0, 5'd6, 5'd5}, 4'd0);
      n = 0;
      while (req_hs_count - snap_hs < 2 && n < 50) begin @(negedge clk); n++; end
      check("reset_test_reqs", req_hs_count - snap_hs, 2);
      fire_req++;
      repeat (3) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      inject_tag = 2'd1;
      inject_req++;
      @(negedge clk);
      check("post_reset_idle", {bus.in_ready, bus.req_valid, bus.out_valid}, 3'b100);
      check("post_reset_data", bus.out_data, 0);
      exp_req.delete(); exp_out.delete();
      rsp_mode = 0; fire_done = fire_req;
      @(posedge clk); #1 reset = 1'b0;
      cur_salt = $urandom;
      issue(2'd2, 1'b1, 3'b011, {5'd0, 5'd12, 5'd13}, 4'd0);
      wait_done(100);

      // randomized traffic with random backpressure and response order
      req_mode = 1; out_mode = 1; rsp_mode = 2;
      for (int t = 0; t < 40; t++) begin
         cur_salt = $urandom;
         issue(WIS_W'($urandom), SID_W'($urandom), NUM_SRC'($urandom),
               (NUM_SRC*REG_BITS)'($urandom), VL_WIDTH'($urandom_range(0, 3)));
         wait_done(400);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
